graph_result_packer: RTL
========================

GRAPH_RESULT_PACKER -- requirements
Module: graph_result_packer

Interface
- REQ-001: Parameter CKSUM_EN, default 1; 1 appends an XOR checksum byte to each frame, 0 omits it.
- REQ-002: clk  input  1  single clock; all state changes on rising edge.
- REQ-003: rst  input  1  synchronous, active-high reset.
- REQ-004: in_valid  input  1  result word present on in_x/in_y/in_z.
- REQ-005: in_ready  output  1  packer can accept a result word this cycle.
- REQ-006: in_x  input  4  upstream X result.
- REQ-007: in_y  input  10  upstream Y result.
- REQ-008: in_z  input  8  upstream Z result.
- REQ-009: out_valid  output  1  out_data holds a valid byte.
- REQ-010: out_ready  input  1  downstream accepts the byte this cycle.
- REQ-011: out_data  output  8  serialized byte.
- REQ-012: out_last  output  1  marks the final byte of a frame; qualified by out_valid.
- REQ-013: frame_cnt  output  8  count of completed frames, wraps modulo 256.

Function
- REQ-014: Input transfer occurs when in_valid && in_ready are both high on a rising edge; output transfer occurs when out_valid && out_ready are both high.
- REQ-015: FSM states: IDLE, B0, B1, B2, CK; in_ready SHALL be 1 only in IDLE and rst low.
- REQ-016: On an input transfer, in_x/in_y/in_z SHALL be captured into an internal 22-bit holding register, and the FSM SHALL go IDLE->B0.
- REQ-017: Byte map: B0 = in_z[7:0]; B1 = in_y[7:0]; B2 = {in_x[3:0], 2'b00, in_y[9:8]}; CK = B0 ^ B1 ^ B2.
- REQ-018: In B0, B1, B2 and CK, out_valid SHALL be 1 and out_data SHALL be the byte for that state, driven from registers and not from live inputs.
- REQ-019: State SHALL advance B0->B1->B2 only on an output transfer; from B2, advance to CK if CKSUM_EN=1, otherwise to IDLE.
- REQ-020: From CK, advance to IDLE on an output transfer.
- REQ-021: out_last SHALL be 1 in CK when CKSUM_EN=1, and in B2 when CKSUM_EN=0; it is 0 in all other states.
- REQ-022: With out_ready low, out_data, out_last and out_valid SHALL hold unchanged; no byte is dropped or duplicated.
- REQ-023: Upstream input changes while not in IDLE SHALL NOT affect the frame in progress.
- REQ-024: frame_cnt SHALL increment by 1 on the transfer of the out_last byte; 8'hFF wraps to 8'h00.
- REQ-025: Latency: first byte valid on the cycle after the input transfer; with out_ready held high, a frame takes 4 cycles (CKSUM_EN=1) or 3 cycles (CKSUM_EN=0), plus 1 IDLE cycle before the next input transfer.
- REQ-026: Bits 3:2 of B2 SHALL always be 0.

Reset
- REQ-027: While rst is high on a clock edge, the FSM SHALL go to IDLE and out_valid=0, out_last=0, out_data=8'h00, frame_cnt=8'h00, holding register=0.
- REQ-028: in_ready SHALL be 0 during any cycle in which rst is high.
- REQ-029: Reset asserted mid-frame SHALL abort the frame: no further bytes, frame_cnt=0, and the next frame starts cleanly at B0.

Verification
- REQ-030: Single frame, CKSUM_EN=1, out_ready=1: in_x=4'hA, in_y=10'h3FD, in_z=8'h2C -> bytes 0x2C, 0xFD, 0xA3, 0x72 on consecutive cycles, out_last only on 0x72, frame_cnt 0->1.
- REQ-031: Same input with CKSUM_EN=0 -> bytes 0x2C, 0xFD, 0xA3 with out_last on 0xA3; frame_cnt=1.
- REQ-032: Backpressure: out_ready=0 for 5 cycles while in B1 -> out_data stays 0xFD with out_valid=1; the remaining bytes follow intact after out_ready=1; in_ready stays 0 throughout.
- REQ-033: Input mutation: change in_y to 10'h000 during B0 -> frame still emits 0xFD and 0xA3.
- REQ-034: Wrap: 256 back-to-back frames -> frame_cnt returns to 8'h00; one IDLE cycle with in_ready=1 between frames.
- REQ-035: Mid-frame reset: assert rst in B2 -> the next cycle has out_valid=0, out_data=0, frame_cnt=0; the following frame emits correct bytes from B0.

Source files
------------

// File: rtl/graph_result_packer.sv
// Purpose : serialize one {x,y,z} graph result into a 3-byte frame, plus an optional XOR checksum byte.
// Latency : first byte is valid the cycle after the input transfer; one byte per cycle while out_ready is high.
// Backpr. : in_ready is high only in IDLE; out_* hold steady while out_ready is low.
//
// Ports:
//   clk, rst             - single clock, synchronous active-high reset
//   in_valid/in_ready    - result word handshake; in_x[3:0], in_y[9:0], in_z[7:0]
//   out_valid/out_ready  - byte handshake; out_data[7:0], out_last marks the final byte of a frame
//   frame_cnt[7:0]       - completed frames, wraps modulo 256
module graph_result_packer #(
    parameter int CKSUM_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_x,
    input  logic [9:0] in_y,
    input  logic [7:0] in_z,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic [7:0] frame_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B0   = 3'd1,
        B1   = 3'd2,
        B2   = 3'd3,
        CK   = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // Captured result word; the frame is built only from this, so upstream
    // may change its inputs freely once the word has been accepted.
    logic [3:0] hold_x;
    logic [9:0] hold_y;
    logic [7:0] hold_z;

    logic [7:0] byte0;
    logic [7:0] byte1;
    logic [7:0] byte2;
    logic [7:0] byte_ck;

    logic in_xfer;
    logic out_xfer;

    assign byte0   = hold_z;
    assign byte1   = hold_y[7:0];
    assign byte2   = {hold_x, 2'b00, hold_y[9:8]};
    assign byte_ck = byte0 ^ byte1 ^ byte2;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_x    <= '0;
            hold_y    <= '0;
            hold_z    <= '0;
            frame_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (in_xfer) begin
                hold_x <= in_x;
                hold_y <= in_y;
                hold_z <= in_z;
            end
            if (out_xfer && out_last) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                // rst gating keeps in_ready low on every reset cycle, even
                // though the state register is already IDLE.
                in_ready = !rst;
                if (in_valid && !rst) begin
                    state_nxt = B0;
                end
            end
            B0: begin
                out_valid = 1'b1;
                out_data  = byte0;
                if (out_ready) begin
                    state_nxt = B1;
                end
            end
            B1: begin
                out_valid = 1'b1;
                out_data  = byte1;
                if (out_ready) begin
                    state_nxt = B2;
                end
            end
            B2: begin
                out_valid = 1'b1;
                out_data  = byte2;
                out_last  = (CKSUM_EN == 0);
                if (out_ready) begin
                    state_nxt = (CKSUM_EN != 0) ? CK : IDLE;
                end
            end
            CK: begin
                out_valid = 1'b1;
                out_data  = byte_ck;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
